uart_rcvr: RTL and testbench

UART_RCVR -- requirements
Module: uart_rcvr

---
 rtl/uart_rcvr.sv | 173 +++++++++++++++++
 tb/tb_uart_rcvr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcvr.sv
// ---------------------------------------------------------------------------
// uart_rcvr -- 8N1 UART receiver
//
// Oversamples an asynchronous serial line with a bit-period counter and
// recovers one character per frame (start bit, 8 data bits LSB first, stop
// bit). The line is passed through a two-flop synchronizer before any
// decision is made on it. Each data bit, and the stop bit, is sampled at its
// midpoint. The receiver returns to IDLE at the stop-bit midpoint, so frames
// may follow each other with no idle time between them.
//
// Parameters
//   CLKS_PER_BIT : serial_clock cycles per bit; even, >= 4
//
// Ports
//   serial_clock : single clock, rising-edge active
//   reset        : synchronous, active-high
//   serial_in    : asynchronous UART line, idles high
//   char_out     : last correctly received character (held between strobes)
//   char_valid   : one-cycle strobe, char_out has just been updated
// ---------------------------------------------------------------------------
module uart_rcvr #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       serial_clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] char_out,
    output logic       char_valid
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    // Counter compare points: mid start bit, then full bit periods that land
    // on the midpoint of each following bit.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    // Synchronizer
    logic          sync_meta_q, sync_meta_d;
    logic          rx_q, rx_d;

    // Receiver state
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    char_q, char_d;
    logic          valid_q, valid_d;

    // -----------------------------------------------------------------------
    // Synchronizer next-state
    // -----------------------------------------------------------------------
    always_comb begin
        sync_meta_d = serial_in;
        rx_d        = sync_meta_q;
    end

    // -----------------------------------------------------------------------
    // Receiver next-state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        char_d  = char_q;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_q) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        // Line went high again before mid start bit: glitch.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_q) begin
                        char_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Framing error or break: discard and wait for the
                        // line to return high before hunting for a new start.
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            sync_meta_q <= 1'b1;
            rx_q        <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            char_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            sync_meta_q <= sync_meta_d;
            rx_q        <= rx_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            char_q      <= char_d;
            valid_q     <= valid_d;
        end
    end

    assign char_out   = char_q;
    assign char_valid = valid_q;

endmodule

// File: tb/tb_uart_rcvr.sv
// ---------------------------------------------------------------------------
// tb_uart_rcvr -- self-checking bench for uart_rcvr
//
// Frames are serialised bit by bit from the bench. A frame that should be
// accepted is entered into an expectation queue together with the cycle at
// which its strobe is due (computed from the frame start with the latency
// formula). A monitor on the falling edge matches strobes against the queue,
// tracks the value char_out must hold, and flags double strobes.
// ---------------------------------------------------------------------------
module tb_uart_rcvr;

    localparam int unsigned C = 16;

    typedef struct {
        logic [7:0]  data;
        int unsigned due;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [7:0] char_out;
    logic       char_valid;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned cyc;
    logic        rst_seen;
    logic        prev_valid;
    logic [7:0]  model_char;
    exp_t        exp_q[$];
    exp_t        mon_e;

    uart_rcvr #(.CLKS_PER_BIT(C)) dut (
        .serial_clock (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .char_out     (char_out),
        .char_valid   (char_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    // Monitor: everything is sampled half a cycle after the active edge.
    always @(negedge clk) begin
        if (rst_seen) begin
            model_char = 8'h00;
            check_eq("valid_in_reset", {31'd0, char_valid}, 32'd0);
            check_eq("char_in_reset", {24'd0, char_out}, 32'd0);
        end else begin
            if (char_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_strobe", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("latency_in_window",
                             {31'd0, (cyc + 2 >= mon_e.due) && (cyc <= mon_e.due + 2)}, 32'd1);
                    model_char = mon_e.data;
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].due + 2) begin
                mon_e = exp_q.pop_front();
                check_eq("missing_strobe", {24'd0, mon_e.data}, 32'hFFFF_FFFF);
            end
            check_eq("char_out", {24'd0, char_out}, {24'd0, model_char});
            check_eq("no_double_strobe", {31'd0, prev_valid & char_valid}, 32'd0);
        end
        prev_valid = char_valid;
    end

    // All driving happens 1 time unit after a rising edge.
    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        wait_cycles(C);
    endtask

    task automatic idle_bits(input int unsigned n);
        serial_in = 1'b1;
        wait_cycles(n * C);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit expect_ok);
        exp_t e;
        if (expect_ok) begin
            // Start bit is first sampled at the next edge, cyc + 1.
            e.data = d;
            e.due  = cyc + 1 + 2 + C / 2 + 9 * C;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int unsigned i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    string letters;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        rst_seen   = 1'b1;
        prev_valid = 1'b0;
        model_char = 8'h00;
        reset      = 1'b1;
        serial_in  = 1'b1;

        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("reset_char_out", {24'd0, char_out}, 32'd0);
        check_eq("reset_char_valid", {31'd0, char_valid}, 32'd0);

        // Single character
        idle_bits(2);
        send_frame(8'h55, 1'b1, 1'b1);
        idle_bits(2);

        // Alphabet back to back
        letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        for (int unsigned i = 0; i < 26; i++) send_frame(letters[i], 1'b1, 1'b1);
        idle_bits(2);

        // Short low glitch, then a real frame
        serial_in = 1'b0;
        wait_cycles(4);
        idle_bits(2);
        send_frame(8'hA3, 1'b1, 1'b1);
        idle_bits(2);

        // Framing error followed by a long break
        send_frame(8'h3C, 1'b0, 1'b0);
        serial_in = 1'b0;
        wait_cycles(40 * C);
        idle_bits(2);
        send_frame(8'h7E, 1'b1, 1'b1);
        idle_bits(2);

        // Reset in the middle of data bit 4 of 0xFF
        drive_bit(1'b0);
        for (int unsigned i = 0; i < 4; i++) drive_bit(1'b1);
        serial_in = 1'b1;
        wait_cycles(C / 2);
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        check_eq("abort_char_out", {24'd0, char_out}, 32'd0);
        check_eq("abort_char_valid", {31'd0, char_valid}, 32'd0);
        idle_bits(2);
        send_frame(8'h81, 1'b1, 1'b1);
        idle_bits(1);

        // Extreme data values back to back
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle_bits(2);

        // Randomised traffic with occasional framing errors
        for (int unsigned i = 0; i < 24; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                send_frame(d, 1'b0, 1'b0);
                serial_in = 1'b0;
                wait_cycles($urandom_range(0, 3) * C);
                idle_bits(1);
            end else begin
                send_frame(d, 1'b1, 1'b1);
                idle_bits($urandom_range(0, 2));
            end
        end

        // Drain: the monitor retires late expectations itself, so this is bounded.
        serial_in = 1'b1;
        for (int unsigned i = 0; i < 20 * C && exp_q.size() != 0; i++) @(posedge clk);
        wait_cycles(4);
        check_eq("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
